// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first, through a single registered cell.
// Optional unsigned saturation is compiled in with SERIAL_ADDSUB_SATURATE_EN.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             mode_q, cy_q, cb_q, zero_q, ovf_q;

    logic             last_bit, a_bit, b_bit, sum_bit, cy_next, ovf_next;
    logic [WIDTH-1:0] res_full, res_fin;

    assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    // Operands shift right each bit cycle, so bit 0 is always the current bit
    // and on the last cycle it holds the original MSB.
    assign a_bit    = a_q[0];
    assign b_bit    = b_q[0];
    assign sum_bit  = a_bit ^ b_bit ^ cy_q;
    assign cy_next  = mode_q ? ((a_bit & b_bit) | (a_bit & cy_q) | (b_bit & cy_q))
                             : ((~a_bit & b_bit) | (~(a_bit ^ b_bit) & cy_q));
    assign ovf_next = mode_q ? ((a_bit == b_bit) && (sum_bit != a_bit))
                             : ((a_bit != b_bit) && (sum_bit != a_bit));
    assign res_full = {sum_bit, res_q[WIDTH-1:1]};

`ifdef SERIAL_ADDSUB_SATURATE_EN
    // Overflow above uses the raw MSB; only the stored result is clamped.
    assign res_fin = cy_next ? (mode_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}}) : res_full;
`else
    assign res_fin = res_full;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready) state_d = RUN;
            RUN:     if (last_bit)             state_d = DONE;
            DONE:    if (out_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it stays low for the whole reset window.
    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            mode_q <= 1'b0;
            cy_q   <= 1'b0;
            cb_q   <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q    <= operand_a;
                    b_q    <= operand_b;
                    mode_q <= mode;
                    cnt_q  <= '0;
                    cy_q   <= 1'b0;
                end
                RUN: begin
                    a_q  <= a_q >> 1;
                    b_q  <= b_q >> 1;
                    cy_q <= cy_next;
                    if (last_bit) begin
                        cnt_q  <= '0;
                        res_q  <= res_fin;
                        cb_q   <= cy_next;
                        ovf_q  <= ovf_next;
                        zero_q <= (res_fin == '0);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        res_q <= res_full;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result       = res_q;
    assign carry_borrow = cb_q;
    assign zero         = zero_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed + random bench for serial_addsub (WIDTH=6) against an arithmetic reference model.
module tb_serial_addsub;
    localparam int W = 6;
    localparam int MASK = (1 << W) - 1;

    logic         clk, rst_n, in_valid, in_ready, mode, out_valid, out_ready;
    logic [W-1:0] operand_a, operand_b, result;
    logic         carry_borrow, zero, overflow;

    int n_cmp = 0;
    int n_bad = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_borrow(carry_borrow), .zero(zero), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed/unsigned integer arithmetic, no bit-level modelling.
    task automatic model(input logic m, input int a, input int b,
                         output int r, output int cb, output int z, output int ov);
        int sa, sb, st, raw;
        sa  = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb  = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        st  = m ? sa + sb : sa - sb;
        ov  = (st > (1 << (W-1)) - 1 || st < -(1 << (W-1))) ? 1 : 0;
        raw = m ? a + b : a - b;
        cb  = m ? ((raw > MASK) ? 1 : 0) : ((a < b) ? 1 : 0);
        r   = raw & MASK;
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (cb == 1) r = m ? MASK : 0;
`endif
        z   = (r == 0) ? 1 : 0;
    endtask

    task automatic run_op(input logic m, input int a, input int b, input int hold,
                          input bit pulse, input string tag);
        int er, ecb, ez, eov;
        model(m, a, b, er, ecb, ez, eov);
        @(negedge clk);
        chk({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1; mode = m; operand_a = W'(a); operand_b = W'(b);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k < W; k++) begin
            if (pulse && k == 2) begin
                in_valid = 1'b1; mode = ~m; operand_a = ~W'(a); operand_b = W'(a);
            end else in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, " early out_valid"}, out_valid, 0);
        @(negedge clk);
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " result"}, result, er);
        chk({tag, " carry_borrow"}, carry_borrow, ecb);
        chk({tag, " zero"}, zero, ez);
        chk({tag, " overflow"}, overflow, eov);
        for (int h = 0; h < hold; h++) begin
            in_valid = pulse && (h == 1);
            if (pulse) begin mode = ~m; operand_a = W'(b); operand_b = ~W'(b); end
            @(negedge clk);
            chk({tag, " held result"}, {result, carry_borrow, zero, overflow},
                {W'(er), ecb[0], ez[0], eov[0]});
            chk({tag, " held in_ready"}, {out_valid, in_ready}, 2'b10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " handoff out_valid"}, out_valid, 0);
        chk({tag, " handoff in_ready"}, in_ready, 1);
        if (pulse) begin
            repeat (W + 2) @(negedge clk);
            chk({tag, " dropped op"}, {out_valid, in_ready}, 2'b01);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
        operand_a = '0; operand_b = '0;
        #1;
        chk("reset outputs", {in_ready, out_valid, result, carry_borrow, zero, overflow}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post-reset in_ready", in_ready, 1);

        run_op(1'b0, 10, 4, 0, 0, "sub basic");
        run_op(1'b0, 1, 2, 0, 0, "sub underflow");
        run_op(1'b1, 63, 1, 0, 0, "add wrap");
        run_op(1'b1, 31, 1, 0, 0, "add ovf");
        run_op(1'b0, 32, 1, 0, 0, "sub ovf");
        run_op(1'b0, 5, 5, 0, 0, "sub zero");
        run_op(1'b1, 45, 19, 5, 1, "backpressure");

        // Reset while bit 3 is being processed.
        @(negedge clk);
        in_valid = 1'b1; mode = 1'b1; operand_a = 6'd21; operand_b = 6'd13;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("mid-run reset outputs",
               {in_ready, out_valid, result, carry_borrow, zero, overflow}, 0);
        @(negedge clk);
        chk("reset held outputs", {in_ready, out_valid, result, carry_borrow, zero, overflow}, 0);
        rst_n = 1'b1;
        #1 chk("reset release in_ready", in_ready, 1);
        run_op(1'b0, 3, 1, 0, 0, "after reset");

        for (int i = 0; i < 40; i++)
            run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, MASK)),
                   int'($urandom_range(0, MASK)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
